smm_param: RTL and testbench

SMM_PARAM -- requirements
Module: smm_param

---
 rtl/smm_pkg.sv | 22 ++
 rtl/smm_dot.sv | 32 +++
 rtl/smm_param.sv | 171 +++++++++++++++++
 tb/tb_smm_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smm_pkg.sv
// Shared types and helpers for the sparse matrix multiplier: FSM states,
// size decode and drain length.
package smm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned DRAIN_LEN = 2;

  // Dimension code to matrix size, clamped to the largest supported size.
  function automatic int unsigned size_decode(input logic [1:0] code, input int unsigned max_n);
    int unsigned n;
    n = 32'd4 << code;
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/smm_dot.sv
// Dot product of one A row and one B column across MAX_N lanes; lanes with
// lane_en low contribute nothing.
module smm_dot #(
  parameter int unsigned LANES = 32,
  parameter int unsigned VAL_W = 4,
  parameter int unsigned SUM_W = 13
) (
  input  logic [LANES*VAL_W-1:0] a_vec,
  input  logic [LANES*VAL_W-1:0] b_vec,
  input  logic [LANES-1:0]       lane_en,
  output logic [SUM_W-1:0]       sum_c
);

  logic [SUM_W-1:0] prod_c [LANES];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_c[k] = '0;
      if (lane_en[k]) begin
        prod_c[k] = SUM_W'(a_vec[k*VAL_W +: VAL_W]) * SUM_W'(b_vec[k*VAL_W +: VAL_W]);
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_c = sum_c + prod_c[k];
    end
  end

endmodule

// File: rtl/smm_param.sv
// Sparse-input matrix multiplier: loads A/B entries, walks C row-major and
// emits nonzero elements. Define SMM_SAT_EN to saturate instead of wrap.
module smm_param
  import smm_pkg::*;
#(
  parameter int unsigned MAX_N = 32,
  parameter int unsigned IDX_W = $clog2(MAX_N),
  parameter int unsigned VAL_W = 4,
  parameter int unsigned OUT_W = 2*VAL_W+IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_size,
  input  logic [1:0]       in_size,
  input  logic             in_valid_a,
  input  logic [IDX_W-1:0] in_row_a,
  input  logic [IDX_W-1:0] in_col_a,
  input  logic [VAL_W-1:0] in_val_a,
  input  logic             in_valid_b,
  input  logic [IDX_W-1:0] in_row_b,
  input  logic [IDX_W-1:0] in_col_b,
  input  logic [VAL_W-1:0] in_val_b,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic [OUT_W-1:0] out_val,
  output logic             out_done,
  output logic             busy
);

  localparam int unsigned N_W   = IDX_W + 1;
  localparam int unsigned SUM_W = 2*VAL_W + IDX_W;
  localparam int unsigned EXT_W = (OUT_W > SUM_W) ? OUT_W : SUM_W;

  state_t           state_q, state_d;
  logic [N_W-1:0]   n_q;
  logic [N_W-1:0]   n_last_c;
  logic [IDX_W-1:0] r_q, c_q;
  logic [1:0]       drain_q;
  logic             last_col_c, last_elem_c, start_c;

  logic [VAL_W-1:0] a_mem [MAX_N][MAX_N];
  logic [VAL_W-1:0] b_mem [MAX_N][MAX_N];

  logic [MAX_N*VAL_W-1:0] a_vec_c, b_vec_c;
  logic [MAX_N-1:0]       lane_en_c;
  logic [SUM_W-1:0]       dot_c, dot_q;
  logic                   dv_q;
  logic [IDX_W-1:0]       dr_q, dc_q;
  logic [OUT_W-1:0]       res_c;
  logic                   emit_c;

  assign start_c     = (state_q == IDLE) && in_valid_size;
  assign n_last_c    = n_q - N_W'(1);
  assign last_col_c  = (N_W'(c_q) == n_last_c);
  assign last_elem_c = last_col_c && (N_W'(r_q) == n_last_c);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_size) state_d = LOAD;
      LOAD:    if (!in_valid_a && !in_valid_b) state_d = CALC;
      CALC:    if (last_elem_c) state_d = DRAIN;
      DRAIN:   if (drain_q == 2'(DRAIN_LEN-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, size, walk counters and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      drain_q  <= '0;
      busy     <= 1'b0;
      out_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d != IDLE);
      out_done <= (state_d == DONE);
      if (start_c) n_q <= N_W'(size_decode(in_size, MAX_N));
      if (state_q != CALC) begin
        r_q <= '0;
        c_q <= '0;
      end else if (last_col_c) begin
        c_q <= '0;
        r_q <= r_q + IDX_W'(1);
      end else begin
        c_q <= c_q + IDX_W'(1);
      end
      drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
    end
  end

  // Operand stores: cleared at job start, written only while loading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_N; i++)
        for (int j = 0; j < MAX_N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
    end else if (start_c) begin
      for (int i = 0; i < MAX_N; i++)
        for (int j = 0; j < MAX_N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
    end else if (state_q == LOAD) begin
      if (in_valid_a && (N_W'(in_row_a) < n_q) && (N_W'(in_col_a) < n_q))
        a_mem[in_row_a][in_col_a] <= in_val_a;
      if (in_valid_b && (N_W'(in_row_b) < n_q) && (N_W'(in_col_b) < n_q))
        b_mem[in_row_b][in_col_b] <= in_val_b;
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_N; k++) begin
      a_vec_c[k*VAL_W +: VAL_W] = a_mem[r_q][k];
      b_vec_c[k*VAL_W +: VAL_W] = b_mem[k][c_q];
      lane_en_c[k]              = (N_W'(k) < n_q);
    end
  end

  smm_dot #(
    .LANES (MAX_N),
    .VAL_W (VAL_W),
    .SUM_W (SUM_W)
  ) u_dot (
    .a_vec   (a_vec_c),
    .b_vec   (b_vec_c),
    .lane_en (lane_en_c),
    .sum_c   (dot_c)
  );

`ifdef SMM_SAT_EN
  assign res_c = (EXT_W'(dot_q) > EXT_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : OUT_W'(dot_q);
`else
  assign res_c = OUT_W'(dot_q);
`endif

  assign emit_c = dv_q && (res_c != '0);

  // Two-stage result pipeline: dot product, then gated output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q      <= 1'b0;
      dot_q     <= '0;
      dr_q      <= '0;
      dc_q      <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_val   <= '0;
    end else begin
      dv_q      <= (state_q == CALC);
      dot_q     <= dot_c;
      dr_q      <= r_q;
      dc_q      <= c_q;
      out_valid <= emit_c;
      out_row   <= emit_c ? dr_q : '0;
      out_col   <= emit_c ? dc_q : '0;
      out_val   <= emit_c ? res_c : '0;
    end
  end

endmodule

// File: tb/tb_smm_param.sv
// Directed bench for smm_param: a default instance plus an 8-bit-result
// instance sharing the same stimulus for the overflow case.
module tb_smm_param;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned VAL_W  = 4;
  localparam int unsigned OUT_W  = 13;
  localparam int unsigned SOUT_W = 8;
`ifdef SMM_SAT_EN
  localparam longint EXP_S = 255;
`else
  localparam longint EXP_S = 132;
`endif

  logic clk, rst_n;
  logic in_valid_size;
  logic [1:0] in_size;
  logic in_valid_a, in_valid_b;
  logic [IDX_W-1:0] in_row_a, in_col_a, in_row_b, in_col_b;
  logic [VAL_W-1:0] in_val_a, in_val_b;
  logic out_valid, out_done, busy;
  logic [IDX_W-1:0] out_row, out_col;
  logic [OUT_W-1:0] out_val;
  logic s_out_valid, s_out_done, s_busy;
  logic [IDX_W-1:0] s_out_row, s_out_col;
  logic [SOUT_W-1:0] s_out_val;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int bad_zero = 0;
  int q_row[$], q_col[$], q_val[$], q_cyc[$], done_cyc[$];
  int s_row[$], s_col[$], s_val[$];
  int s_done = 0;

  smm_param u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid_size(in_valid_size), .in_size(in_size),
    .in_valid_a(in_valid_a), .in_row_a(in_row_a), .in_col_a(in_col_a), .in_val_a(in_val_a),
    .in_valid_b(in_valid_b), .in_row_b(in_row_b), .in_col_b(in_col_b), .in_val_b(in_val_b),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_val(out_val),
    .out_done(out_done), .busy(busy)
  );

  smm_param #(.OUT_W(SOUT_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid_size(in_valid_size), .in_size(in_size),
    .in_valid_a(in_valid_a), .in_row_a(in_row_a), .in_col_a(in_col_a), .in_val_a(in_val_a),
    .in_valid_b(in_valid_b), .in_row_b(in_row_b), .in_col_b(in_col_b), .in_val_b(in_val_b),
    .out_valid(s_out_valid), .out_row(s_out_row), .out_col(s_out_col), .out_val(s_out_val),
    .out_done(s_out_done), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (out_valid) begin
      q_row.push_back(int'(out_row));
      q_col.push_back(int'(out_col));
      q_val.push_back(int'(out_val));
      q_cyc.push_back(cyc);
    end else if (out_row != '0 || out_col != '0 || out_val != '0) begin
      bad_zero++;
    end
    if (out_done) done_cyc.push_back(cyc);
    if (s_out_valid) begin
      s_row.push_back(int'(s_out_row));
      s_col.push_back(int'(s_out_col));
      s_val.push_back(int'(s_out_val));
    end
    if (s_out_done) s_done++;
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] code);
    in_valid_size = 1'b1;
    in_size       = code;
    step();
    in_valid_size = 1'b0;
  endtask

  task automatic put(input bit va, input int ra, input int ca, input int xa,
                     input bit vb, input int rb, input int cb, input int xb);
    in_valid_a = va; in_row_a = IDX_W'(ra); in_col_a = IDX_W'(ca); in_val_a = VAL_W'(xa);
    in_valid_b = vb; in_row_b = IDX_W'(rb); in_col_b = IDX_W'(cb); in_val_b = VAL_W'(xb);
    step();
  endtask

  task automatic end_load(output int p);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    step();
    p = cyc;
  endtask

  // Optionally pokes size/A strobes mid-CALC (must be ignored), then waits for out_done.
  task automatic wait_done(input int dbase, input int budget, input bit poke);
    int n = 0;
    if (poke) begin
      step();
      step();
      in_valid_size = 1'b1; in_size = 2'd0;
      in_valid_a = 1'b1; in_row_a = IDX_W'(31); in_col_a = '0; in_val_a = '0;
      step();
      in_valid_size = 1'b0;
      in_valid_a = 1'b0;
    end
    while (done_cyc.size() <= dbase && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_eq("done_timeout", 0, 1);
    repeat (3) step();
  endtask

  task automatic test_identity(input string tag);
    int qb, db, zb, p;
    qb = q_row.size(); db = done_cyc.size(); zb = bad_zero;
    start_job(2'd0);
    put(1, 0, 0, 1, 1, 1, 2, 7);
    put(1, 1, 1, 1, 0, 0, 0, 0);
    put(1, 2, 2, 1, 0, 0, 0, 0);
    put(1, 3, 3, 1, 0, 0, 0, 0);
    end_load(p);
    wait_done(db, 200, 1'b1);
    check_eq({tag, "_cnt"}, q_row.size() - qb, 1);
    if (q_row.size() > qb) begin
      check_eq({tag, "_row"}, q_row[qb], 1);
      check_eq({tag, "_col"}, q_col[qb], 2);
      check_eq({tag, "_val"}, q_val[qb], 7);
      check_eq({tag, "_lat"}, q_cyc[qb], p + 8);
    end
    check_eq({tag, "_done_cnt"}, done_cyc.size() - db, 1);
    if (done_cyc.size() > db) check_eq({tag, "_done_cyc"}, done_cyc[db], p + 18);
    check_eq({tag, "_zero_gate"}, bad_zero - zb, 0);
    check_eq({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int qb, db, sb, sdb, p;
    rst_n = 1'b0;
    in_valid_size = 1'b0; in_size = '0;
    in_valid_a = 1'b0; in_row_a = '0; in_col_a = '0; in_val_a = '0;
    in_valid_b = 1'b0; in_row_b = '0; in_col_b = '0; in_val_b = '0;
    #12;
    check_eq("reset_outputs", longint'({out_valid, out_row, out_col, out_val, out_done, busy}), 0);
    step();
    rst_n = 1'b1;
    step();

    test_identity("ident");

    // Full density, all 15: every element 32*225
    qb = q_row.size(); db = done_cyc.size();
    start_job(2'd3);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        put(1, r, c, 15, 1, r, c, 15);
    end_load(p);
    wait_done(db, 1200, 1'b1);
    check_eq("full_cnt", q_row.size() - qb, 1024);
    for (int i = 0; i < 1024 && qb + i < q_row.size(); i++) begin
      check_eq("full_elem", (longint'(q_row[qb+i]) << 32) | (longint'(q_col[qb+i]) << 16) | q_val[qb+i],
               (longint'(i / 32) << 32) | (longint'(i % 32) << 16) | 7200);
      check_eq("full_cyc", q_cyc[qb+i], p + i + 2);
    end
    check_eq("full_done_cnt", done_cyc.size() - db, 1);
    if (done_cyc.size() > db) check_eq("full_done_cyc", done_cyc[db], p + 1026);

    // Empty product: A only in col 0, B only in row 5
    qb = q_row.size(); db = done_cyc.size();
    start_job(2'd1);
    for (int r = 0; r < 8; r++) put(1, r, 0, r + 1, 1, 5, r, r + 1);
    end_load(p);
    wait_done(db, 300, 1'b0);
    check_eq("empty_cnt", q_row.size() - qb, 0);
    check_eq("empty_done_cnt", done_cyc.size() - db, 1);
    if (done_cyc.size() > db) check_eq("empty_done_cyc", done_cyc[db], p + 66);

    // Filter: out-of-range dropped, last write wins, zero write clears
    qb = q_row.size(); db = done_cyc.size();
    start_job(2'd0);
    put(1, 6, 0, 9, 1, 0, 6, 4);
    put(1, 0, 6, 9, 1, 6, 6, 9);
    put(1, 0, 0, 3, 1, 0, 0, 2);
    put(1, 0, 0, 5, 1, 1, 1, 3);
    put(1, 1, 1, 4, 0, 0, 0, 0);
    put(1, 1, 1, 0, 0, 0, 0, 0);
    end_load(p);
    wait_done(db, 200, 1'b0);
    check_eq("filter_cnt", q_row.size() - qb, 1);
    if (q_row.size() > qb) begin
      check_eq("filter_elem", (longint'(q_row[qb]) << 32) | (longint'(q_col[qb]) << 16) | q_val[qb], 10);
      check_eq("filter_lat", q_cyc[qb], p + 2);
    end

    // Overflow: 4*225 = 900 into an 8-bit result
    qb = q_row.size(); db = done_cyc.size(); sb = s_val.size(); sdb = s_done;
    start_job(2'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        put(1, r, c, 15, 1, r, c, 15);
    end_load(p);
    wait_done(db, 200, 1'b0);
    check_eq("sat_main_cnt", q_row.size() - qb, 16);
    check_eq("sat_narrow_cnt", s_val.size() - sb, 16);
    for (int i = 0; i < 16 && qb + i < q_val.size(); i++)
      check_eq("sat_main_val", q_val[qb+i], 900);
    for (int i = 0; i < 16 && sb + i < s_val.size(); i++)
      check_eq("sat_narrow_elem", (longint'(s_row[sb+i]) << 32) | (longint'(s_col[sb+i]) << 16) | s_val[sb+i],
               (longint'(i / 4) << 32) | (longint'(i % 4) << 16) | EXP_S);
    check_eq("sat_narrow_done", s_done - sdb, 1);

    // Reset in mid-CALC
    start_job(2'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        put(1, r, c, 15, 1, r, c, 15);
    end_load(p);
    repeat (6) step();
    check_eq("rst_pre_valid", out_valid, 1);
    check_eq("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_outputs", longint'({out_valid, out_row, out_col, out_val, out_done, busy}), 0);
    check_eq("rst_narrow_busy", s_busy, 0);
    step();
    step();
    rst_n = 1'b1;
    qb = q_row.size(); db = done_cyc.size();
    repeat (40) step();
    check_eq("rst_no_valid", q_row.size() - qb, 0);
    check_eq("rst_no_done", done_cyc.size() - db, 0);

    test_identity("rst_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
